// File: rtl/tdm_pkg.sv
// Shared definitions for the four-lane TDM demultiplexer.
package tdm_pkg;

  localparam int NUM_LANES     = 4;
  localparam int DEFAULT_WIDTH = 8;

  typedef logic [1:0] slot_t;

  localparam slot_t SLOT_FIRST = 2'd0;
  localparam slot_t SLOT_LAST  = 2'd3;

  // Slot following s; the 2-bit width makes 3 wrap to 0.
  function automatic slot_t next_slot(input slot_t s);
    return s + 2'd1;
  endfunction

endpackage

// File: rtl/tdm_slot_cnt.sv
// Slot tracker for the TDM demux.
// A valid beat with sof is forced to slot 0. Otherwise it takes the current slot.
// A sof that arrives while mid-frame latches a sticky sync error.
module tdm_slot_cnt
  import tdm_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  i_valid,
  input  logic  i_sof,
  output slot_t o_slot,
  output slot_t o_target,
  output logic  o_sync_err
);

  slot_t r_slot;
  logic  r_sync_err;

  // The target only matters when i_valid is high. It is left ungated so the lane decode stays shallow.
  assign o_target   = i_sof ? SLOT_FIRST : r_slot;
  assign o_slot     = r_slot;
  assign o_sync_err = r_sync_err;

  // Advance past the accepted slot, and flag a sof that arrives while mid-frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot     <= SLOT_FIRST;
      r_sync_err <= 1'b0;
    end else if (i_valid) begin
      r_slot <= next_slot(o_target);
      if (i_sof && (r_slot != SLOT_FIRST)) begin
        r_sync_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/tdm_demux4.sv
// Four-lane TDM demultiplexer.
// Each accepted word lands in the lane selected by the slot tracker one cycle later.
// The lane update is marked by a one-cycle pulse on lane_valid.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     din,
  input  logic                 din_valid,
  input  logic                 sof,
  output logic [WIDTH-1:0]     y0,
  output logic [WIDTH-1:0]     y1,
  output logic [WIDTH-1:0]     y2,
  output logic [WIDTH-1:0]     y3,
  output logic [NUM_LANES-1:0] lane_valid,
  output logic                 frame_done,
  output slot_t                slot,
  output logic                 sync_err
);

  slot_t                w_target;
  logic [WIDTH-1:0]     r_lane [NUM_LANES];
  logic [NUM_LANES-1:0] r_lane_valid;
  logic                 r_frame_done;

  tdm_slot_cnt u_slot_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (din_valid),
    .i_sof      (sof),
    .o_slot     (slot),
    .o_target   (w_target),
    .o_sync_err (sync_err)
  );

  // Capture the accepted word into its lane and raise the matching one-cycle pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        r_lane[i] <= '0;
      end
      r_lane_valid <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_lane_valid <= '0;
      r_frame_done <= 1'b0;
      if (din_valid) begin
        r_lane[w_target]       <= din;
        r_lane_valid[w_target] <= 1'b1;
        r_frame_done           <= (w_target == SLOT_LAST);
      end
    end
  end

  assign y0         = r_lane[0];
  assign y1         = r_lane[1];
  assign y2         = r_lane[2];
  assign y3         = r_lane[3];
  assign lane_valid = r_lane_valid;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_tdm_demux4.sv
// Bench for tdm_demux4.
// It drives directed scenarios followed by random traffic.
// Outputs are compared each cycle against a frame-level reference model.
module tb_tdm_demux4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       din_valid;
  logic       sof;
  logic [7:0] y0, y1, y2, y3;
  logic [3:0] lane_valid;
  logic       frame_done;
  logic [1:0] slot;
  logic       sync_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: the lane contents plus the frame position and error flag.
  int m_lane [4];
  int m_pos;
  bit m_err;
  int m_lv;
  bit m_fd;

  tdm_demux4 #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .sof        (sof),
    .y0         (y0),
    .y1         (y1),
    .y2         (y2),
    .y3         (y3),
    .lane_valid (lane_valid),
    .frame_done (frame_done),
    .slot       (slot),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit v, input bit s, input int d);
    int t;
    if (r) begin
      foreach (m_lane[i]) m_lane[i] = 0;
      m_pos = 0; m_err = 0; m_lv = 0; m_fd = 0;
    end else begin
      m_lv = 0; m_fd = 0;
      if (v) begin
        t = s ? 0 : m_pos;
        if (s && m_pos != 0) m_err = 1;
        m_lane[t] = d;
        m_lv = 1 << t;
        m_fd = (t == 3);
        m_pos = (t + 1) % 4;
      end
    end
  endtask

  task automatic compare_all();
    chk("y0", y0, m_lane[0]);
    chk("y1", y1, m_lane[1]);
    chk("y2", y2, m_lane[2]);
    chk("y3", y3, m_lane[3]);
    chk("lane_valid", lane_valid, m_lv);
    chk("frame_done", frame_done, m_fd);
    chk("slot", slot, m_pos);
    chk("sync_err", sync_err, m_err);
  endtask

  // Apply one cycle of stimulus, advance the model, and compare after the edge.
  task automatic cyc(input bit r, input bit v, input bit s, input logic [7:0] d);
    rst = r; din_valid = v; sof = s; din = d;
    model_step(r, v, s, int'(d));
    @(posedge clk);
    #1;
    compare_all();
  endtask

  int fd_cycle [$];
  int cyc_no;

  initial begin
    rst = 1'b1; din_valid = 1'b0; sof = 1'b0; din = '0;
    m_pos = 0; m_err = 0; m_lv = 0; m_fd = 0;
    foreach (m_lane[i]) m_lane[i] = 0;

    // Reset while junk beats arrive; the reset state must win.
    cyc(1, 1, 1, 8'hEE);
    cyc(1, 1, 0, 8'h77);
    chk("reset_y0", y0, 0);
    chk("reset_slot", slot, 0);

    // A single clean frame.
    cyc(0, 1, 1, 8'hA1); chk("f1_lv0", lane_valid, 4'b0001);
    cyc(0, 1, 0, 8'hB2); chk("f1_lv1", lane_valid, 4'b0010);
    cyc(0, 1, 0, 8'hC3); chk("f1_lv2", lane_valid, 4'b0100);
    cyc(0, 1, 0, 8'hD4); chk("f1_lv3", lane_valid, 4'b1000);
    chk("f1_done", frame_done, 1);
    chk("f1_y", {y0, y1, y2, y3}, 32'hA1B2C3D4);
    chk("f1_err", sync_err, 0);

    // Two frames back to back; frame_done must pulse exactly four cycles apart.
    cyc_no = 0;
    fd_cycle.delete();
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, (i % 4) == 0, 8'(8'h10 + i));
      cyc_no++;
      if (frame_done) fd_cycle.push_back(cyc_no);
    end
    chk("bb_fd_count", fd_cycle.size(), 2);
    if (fd_cycle.size() == 2) chk("bb_fd_gap", fd_cycle[1] - fd_cycle[0], 4);
    chk("bb_y", {y0, y1, y2, y3}, 32'h14151617);
    chk("bb_slot", slot, 0);

    // A sof mid-frame sets the sticky sync error.
    cyc(0, 1, 0, 8'h11);
    cyc(0, 1, 0, 8'h22);
    cyc(0, 1, 1, 8'h33);
    chk("rs_y0", y0, 8'h33);
    chk("rs_y1", y1, 8'h22);
    chk("rs_err", sync_err, 1);
    chk("rs_slot", slot, 1);
    chk("rs_fd", frame_done, 0);
    cyc(0, 0, 0, 8'h00);
    chk("rs_err_sticky", sync_err, 1);

    // Alternating valid and idle cycles.
    cyc(1, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, i == 0, 8'(i + 1));
      cyc(0, 0, 0, 8'hFF);
      chk("tg_idle_lv", lane_valid, 0);
    end
    chk("tg_y", {y0, y1, y2, y3}, 32'h01020304);

    // A reset that coincides with the slot-2 beat.
    cyc(0, 1, 1, 8'h11);
    cyc(0, 1, 0, 8'h22);
    cyc(1, 1, 0, 8'h33);
    chk("mr_y", {y0, y1, y2, y3}, 0);
    cyc(0, 1, 0, 8'h55);
    chk("mr_y0", y0, 8'h55);
    chk("mr_lv", lane_valid, 4'b0001);

    // A sof without a valid beat must be ignored.
    cyc(0, 1, 0, 8'h66);
    chk("sf_slot_before", slot, 2);
    cyc(0, 0, 1, 8'h99);
    chk("sf_slot", slot, 2);
    chk("sf_err", sync_err, 0);
    chk("sf_lv", lane_valid, 0);

    // Random traffic checked against the reference model.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 39) == 0),
          ($urandom_range(0, 9) < 7),
          ($urandom_range(0, 4) == 0),
          8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tdm_demux4.md
TDM_DEMUX4 -- requirements
Module: tdm_demux4

Interface
REQ-001 Parameter WIDTH, default 8, lane data width in bits.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 din  input  WIDTH  time-multiplexed data word.
REQ-005 din_valid  input  1  din carries a slot word this cycle.
REQ-006 sof  input  1  start-of-frame; qualifies a valid word as slot 0.
REQ-007 y0, y1, y2, y3  output  WIDTH each  registered lane outputs, held between updates.
REQ-008 lane_valid  output  4  one-cycle pulse per lane, bit n set when yn updated.
REQ-009 frame_done  output  1  one-cycle pulse when slot 3 is accepted.
REQ-010 slot  output  2  current expected slot index.
REQ-011 sync_err  output  1  sticky resync flag.

Function
REQ-012 A beat is accepted when din_valid=1; no beat is accepted when din_valid=0, and no state changes then except clearing of pulses.
REQ-013 The target slot of an accepted beat is 0 if sof=1, otherwise the current slot value.
REQ-014 The accepted din is written to y[target] at the next rising edge; the other lanes hold their values.
REQ-015 lane_valid[target] is 1 for exactly the cycle after acceptance; all other lane_valid bits are 0.
REQ-016 Latency: din to yn and lane_valid is 1 cycle; no combinational path from inputs to outputs.
REQ-017 After acceptance, slot becomes target+1 modulo 4 (3 wraps to 0).
REQ-018 frame_done is 1 for the cycle after a beat whose target is 3; otherwise it is 0.
REQ-019 sof=1 with din_valid=1 while slot is not 0 sets sync_err=1; the beat still goes to lane 0 and slot becomes 1.
REQ-020 sync_err, once set, remains 1 until rst.
REQ-021 sof=1 with din_valid=0 is ignored: no state change and no error.
REQ-022 Back-to-back valid beats are accepted every cycle at full throughput, without bubbles.
REQ-023 A partial frame followed by sof restarts at lane 0 and does not pulse frame_done for the partial frame.

Reset
REQ-024 While rst=1 at a clock edge, y0..y3, lane_valid, frame_done, slot and sync_err SHALL all be 0 after that edge.
REQ-025 rst has priority over a simultaneous valid beat; that beat is discarded.
REQ-026 Asserting rst mid-frame abandons the frame; the first beat after reset goes to lane 0 whether or not sof is set.

Structure
REQ-027 Shared package tdm_pkg holds NUM_LANES=4, the slot_t typedef (2-bit) and the default WIDTH constant.
REQ-028 The slot counter, including the sof override, wrap and error detect, is the sub-module tdm_slot_cnt; lane registers and pulses stay in tdm_demux4.
REQ-029 The implementation is 120-400 lines of RTL and contains no latches.

Verification
REQ-030 Reset, then valid beats 8'hA1, 8'hB2, 8'hC3, 8'hD4 with sof on the first -> y0..y3 = A1, B2, C3, D4; lane_valid = 0001, 0010, 0100, 1000 on consecutive cycles; frame_done on the 4th; sync_err = 0.
REQ-031 Two consecutive frames with no gap (8 beats) -> slot wraps 3->0; frame_done pulses twice, 4 cycles apart; the second frame overwrites all lanes.
REQ-032 Beats 8'h11, 8'h22, then sof with 8'h33 -> y0 = 33, y1 = 22; sync_err = 1 and stays 1; slot = 1; no frame_done.
REQ-033 din_valid toggling 1,0,1,0 with beats 8'h01..8'h04 -> lanes fill in order 0..3; idle cycles hold outputs and slot; lane_valid = 0 on idle cycles.
REQ-034 Assert rst on the cycle of the slot-2 beat, release, then send 8'h55 without sof -> that beat is discarded; all outputs are 0 after reset; y0 = 55.
REQ-035 sof=1 with din_valid=0 while slot = 2 -> slot stays 2; sync_err stays 0; no lane_valid pulse.
